// File: rtl/psum_acc.sv
// psum_acc: cross-tile partial-sum accumulator between the PE array and the global buffer.
// Accumulates Tch passes of up to Depth pixels and streams saturated sums on the last pass.
module psum_acc #(
  parameter int PsumDWd     = 16,
  parameter int AccDWd      = 20,
  parameter int Depth       = 64,
  parameter int TileConfDWd = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [TileConfDWd-1:0] i_conf_Tw,
  input  logic [4:0]             i_conf_Tch,
  input  logic                   i_pspix_valid,
  output logic                   o_pspix_ready,
  input  logic [PsumDWd-1:0]     i_pspix_data,
  output logic                   o_opix_valid,
  input  logic                   i_opix_ready,
  output logic [PsumDWd-1:0]     o_opix_data,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [TileConfDWd-1:0] DepthConf = TileConfDWd'(Depth);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_LAST, S_DRAIN, S_DONE} state_t;

  state_t                 state, state_nxt;
  logic [TileConfDWd-1:0] tw_eff, pix_cnt, start_tw;
  logic [4:0]             tch, pass_cnt;
  logic [AccDWd-1:0]      acc_mem [Depth];

  logic                   in_hs, out_hs, pix_last, pass_pre_last;
  logic [IdxW-1:0]        idx;
  logic [AccDWd-1:0]      in_ext, acc_sum, last_sum;
  logic [PsumDWd-1:0]     sat_sum;

  assign start_tw      = (i_conf_Tw > DepthConf) ? DepthConf : i_conf_Tw;
  assign in_hs         = i_pspix_valid & o_pspix_ready;
  assign out_hs        = o_opix_valid & i_opix_ready;
  assign pix_last      = (pix_cnt == tw_eff - TileConfDWd'(1));
  assign pass_pre_last = (pass_cnt == tch - 5'd2);
  assign idx           = pix_cnt[IdxW-1:0];

  // Asynchronous read; with Tw_eff == 1 the previous edge's write is already visible here.
  assign in_ext   = {{(AccDWd-PsumDWd){i_pspix_data[PsumDWd-1]}}, i_pspix_data};
  assign acc_sum  = acc_mem[idx] + in_ext;
  assign last_sum = (tch == 5'd1) ? in_ext : acc_sum;

  // In range when every bit above the result's sign bit matches it.
  always_comb begin
    if (&last_sum[AccDWd-1:PsumDWd-1] || ~|last_sum[AccDWd-1:PsumDWd-1])
      sat_sum = last_sum[PsumDWd-1:0];
    else if (last_sum[AccDWd-1])
      sat_sum = {1'b1, {(PsumDWd-1){1'b0}}};
    else
      sat_sum = {1'b0, {(PsumDWd-1){1'b1}}};
  end

  always_comb begin
    o_pspix_ready = 1'b0;
    unique case (state)
      S_ACC:   o_pspix_ready = 1'b1;
      S_LAST:  o_pspix_ready = !o_opix_valid | i_opix_ready;
      default: o_pspix_ready = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: default assigned first so no path through this block infers a latch.
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          if (start_tw == '0 || i_conf_Tch == 5'd0) state_nxt = S_DONE;
          else if (i_conf_Tch == 5'd1)              state_nxt = S_LAST;
          else                                      state_nxt = S_ACC;
        end
      end
      S_ACC:   if (in_hs && pix_last && pass_pre_last) state_nxt = S_LAST;
      S_LAST:  if (in_hs && pix_last) state_nxt = S_DRAIN;
      S_DRAIN: if (out_hs) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      tw_eff       <= '0;
      tch          <= '0;
      pix_cnt      <= '0;
      pass_cnt     <= '0;
      o_opix_valid <= 1'b0;
      o_opix_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && i_start) begin
        tw_eff   <= start_tw;
        tch      <= i_conf_Tch;
        pix_cnt  <= '0;
        pass_cnt <= '0;
      end else if (in_hs) begin
        if (pix_last) begin
          pix_cnt  <= '0;
          pass_cnt <= pass_cnt + 5'd1;
        end else begin
          pix_cnt <= pix_cnt + TileConfDWd'(1);
        end
      end
      // Input handshake wins over output handshake so back-to-back results stay valid.
      if (state == S_LAST && in_hs) begin
        o_opix_valid <= 1'b1;
        o_opix_data  <= sat_sum;
      end else if (out_hs) begin
        o_opix_valid <= 1'b0;
      end
    end
  end

  // NOTE: the accumulator array has no reset; pass 0 overwrites every entry before it is read.
  always_ff @(posedge i_clk) begin
    if (state == S_ACC && in_hs)
      acc_mem[idx] <= (pass_cnt == 5'd0) ? in_ext : acc_sum;
  end

endmodule

// File: tb/tb_psum_acc.sv
// tb_psum_acc: directed table-driven bench for psum_acc plus hand-written multi-cycle sequences.
module tb_psum_acc;

  logic        clk = 1'b0;
  logic        rst, start, pspix_valid, pspix_ready, opix_valid, opix_ready, busy, done;
  logic [9:0]  conf_tw;
  logic [4:0]  conf_tch;
  logic [15:0] pspix_data, opix_data;

  always #5 clk = ~clk;

  psum_acc #(.PsumDWd(16), .AccDWd(20), .Depth(64), .TileConfDWd(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_conf_Tw(conf_tw), .i_conf_Tch(conf_tch),
    .i_pspix_valid(pspix_valid), .o_pspix_ready(pspix_ready), .i_pspix_data(pspix_data),
    .o_opix_valid(opix_valid), .i_opix_ready(opix_ready), .o_opix_data(opix_data),
    .o_busy(busy), .o_done(done)
  );

  typedef struct packed {
    int tw;
    int tch;
    int in_base;
    int n_in;
    int exp_base;
    int n_out;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int feed[$];
  int exp_q[$];
  int got[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Runs one job from the start pulse to o_done; inputs come from feed, results land in got.
  task automatic run_job(input string name, input int tw, input int tch, input int n_consume,
                         input int stall_len, input int hold_val, input int restart_at);
    int fi = 0, first_v = -1, last_out = -1, done_at = -1;
    logic stalled;
    got.delete();
    for (int k = 0; k < 3000 && done_at < 0; k++) begin
      @(negedge clk);
      if (opix_valid && first_v < 0) first_v = k;
      stalled     = (stall_len > 0) && (first_v >= 0) && (k < first_v + stall_len);
      rst         = 1'b0;
      start       = (k == 0) || (k == restart_at);
      conf_tw     = (k == 0) ? 10'(tw) : 10'd7;
      conf_tch    = (k == 0) ? 5'(tch) : 5'd7;
      pspix_valid = (fi < feed.size());
      pspix_data  = (fi < feed.size()) ? 16'(feed[fi]) : 16'h0;
      opix_ready  = !stalled;
      #1;
      if (k == 0) check({name, " idle_ready"}, 32'(pspix_ready), 0);
      if (k == 1) check({name, " busy"}, 32'(busy), 1);
      if (stalled) begin
        check({name, " stall_hold"}, $signed(opix_data), hold_val);
        check({name, " stall_ready"}, 32'(pspix_ready), 0);
      end
      if (pspix_valid && pspix_ready) fi++;
      if (opix_valid && opix_ready) begin
        got.push_back(int'($signed(opix_data)));
        last_out = k;
      end
      if (done) done_at = k;
    end
    start = 1'b0;
    if (done_at < 0) check({name, " done_timeout"}, 0, 1);
    check({name, " consumed"}, fi, n_consume);
    check({name, " n_out"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s out%0d", name, i), got[i], exp_q[i]);
    if (exp_q.size() > 0) check({name, " done_latency"}, done_at, last_out + 1);
    else                  check({name, " done_latency"}, done_at, 1);
    @(negedge clk);
    #1;
    check({name, " done_pulse"}, 32'(done), 0);
    check({name, " idle_after"}, 32'(busy), 0);
  endtask

  vec_t vecs[6];
  int   in_tab[28];
  int   exp_tab[13];

  initial begin
    int   fi;
    logic seen_done;

    in_tab  = '{1, 2, 3, 4, 10, 20, 30, 40, 100, 200, 300, 400,
                32767, -32768, 100, -100,
                -5, 0, 1234,
                -1000, 500, 7, -2000, -600, -7,
                -20000, -20000, 5000};
    exp_tab = '{111, 222, 333, 444,
                32767, -32768,
                -5, 0, 1234,
                -3000, -100, 0,
                -32768};
    vecs[0] = '{tw: 4, tch: 3, in_base: 0,  n_in: 12, exp_base: 0,  n_out: 4};
    vecs[1] = '{tw: 2, tch: 2, in_base: 12, n_in: 4,  exp_base: 4,  n_out: 2};
    vecs[2] = '{tw: 3, tch: 1, in_base: 16, n_in: 3,  exp_base: 6,  n_out: 3};
    vecs[3] = '{tw: 3, tch: 2, in_base: 19, n_in: 6,  exp_base: 9,  n_out: 3};
    vecs[4] = '{tw: 1, tch: 3, in_base: 25, n_in: 3,  exp_base: 12, n_out: 1};
    vecs[5] = '{tw: 3, tch: 0, in_base: 0,  n_in: 0,  exp_base: 0,  n_out: 0};

    rst = 1'b1; start = 1'b0; conf_tw = '0; conf_tch = '0;
    pspix_valid = 1'b0; pspix_data = '0; opix_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst opix_valid", 32'(opix_valid), 0);
    check("rst opix_data", 32'(opix_data), 0);
    check("rst pspix_ready", 32'(pspix_ready), 0);

    for (int v = 0; v < 6; v++) begin
      feed.delete();
      exp_q.delete();
      for (int i = 0; i < vecs[v].n_in; i++)  feed.push_back(in_tab[vecs[v].in_base + i]);
      for (int i = 0; i < vecs[v].n_out; i++) exp_q.push_back(exp_tab[vecs[v].exp_base + i]);
      run_job($sformatf("vec%0d", v), vecs[v].tw, vecs[v].tch, vecs[v].n_in, 0, 0, -1);
    end

    // Output stall right after the first result.
    feed = '{5, 6, 7};
    exp_q = '{5, 6, 7};
    run_job("backpressure", 3, 1, 3, 4, 5, -1);

    // Tw = 0 finishes without touching data.
    feed.delete();
    exp_q.delete();
    run_job("tw0", 0, 2, 0, 0, 0, -1);

    // Tw = 100 is clamped to the 64-entry depth.
    feed.delete();
    exp_q.delete();
    for (int i = 1; i <= 100; i++) feed.push_back(i);
    for (int i = 1; i <= 64; i++)  exp_q.push_back(i);
    run_job("tw100", 100, 1, 64, 0, 0, -1);

    // Single entry read-modify-written on consecutive cycles.
    feed.delete();
    for (int i = 0; i < 16; i++) feed.push_back(2000);
    exp_q = '{32000};
    run_job("tw1_tch16", 1, 16, 16, 0, 0, -1);

    // A start pulse mid-job must not disturb the running configuration.
    feed = '{1, 2, 3, 4, 10, 20, 30, 40, 100, 200, 300, 400};
    exp_q = '{111, 222, 333, 444};
    run_job("ignored_start", 4, 3, 12, 0, 0, 3);

    // Reset during the LAST pass of Tw=4, Tch=2.
    feed = '{1, 2, 3, 4, 10, 20, 30, 40};
    fi = 0;
    for (int k = 0; k < 50 && fi < 6; k++) begin
      @(negedge clk);
      start       = (k == 0);
      conf_tw     = (k == 0) ? 10'd4 : 10'd7;
      conf_tch    = (k == 0) ? 5'd2 : 5'd7;
      pspix_valid = (fi < feed.size());
      pspix_data  = (fi < feed.size()) ? 16'(feed[fi]) : 16'h0;
      opix_ready  = 1'b1;
      #1;
      if (pspix_valid && pspix_ready) fi++;
    end
    check("midrst progress", fi, 6);
    @(negedge clk);
    start = 1'b0; pspix_valid = 1'b0; rst = 1'b1;
    #1;
    check("midrst pre_valid", 32'(opix_valid), 1);
    check("midrst pre_data", $signed(opix_data), 22);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst opix_valid", 32'(opix_valid), 0);
    check("midrst opix_data", 32'(opix_data), 0);
    check("midrst pspix_ready", 32'(pspix_ready), 0);
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst no_done", 32'(seen_done), 0);

    feed = '{9, 8};
    exp_q = '{9, 8};
    run_job("after_rst", 2, 1, 2, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
